// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: D = A - B, one bit per clock, LSB first.
// start/done handshake; D and Bout only change when a full result is ready.
module serial_subtractor #(
    parameter int unsigned N = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] D,
    output logic         Bout
);

    localparam int unsigned CW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t        state, state_next;
    logic [N-1:0]  sa, sb, res;
    logic          bor;
    logic [CW-1:0] count;

    logic          d_bit, bor_next, last_bit;

    assign d_bit    = sa[0] ^ sb[0] ^ bor;
    assign bor_next = (~sa[0] & sb[0]) | (~sa[0] & bor) | (sb[0] & bor);
    assign last_bit = (count == CW'(N - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= StIdle;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            StIdle:  if (start) state_next = StRun;
            StRun:   if (last_bit) state_next = StDone;
            StDone:  state_next = StIdle;
            default: state_next = StIdle;
        endcase
    end

    always_comb begin
        busy = (state == StRun);
        done = (state == StDone);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sa    <= '0;
            sb    <= '0;
            res   <= '0;
            bor   <= 1'b0;
            count <= '0;
            D     <= '0;
            Bout  <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start) begin
                        sa    <= A;
                        sb    <= B;
                        res   <= '0;
                        bor   <= 1'b0;
                        count <= '0;
                    end
                end
                StRun: begin
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    res   <= {d_bit, res[N-1:1]};
                    bor   <= bor_next;
                    count <= count + 1'b1;
                    // Publish the whole result on the final bit, never a partial one.
                    if (last_bit) begin
                        D    <= {d_bit, res[N-1:1]};
                        Bout <= bor_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: vector table, exhaustive sweep with
// scrambled inputs, held-start, and reset-abort sequences.
module tb_serial_subtractor;

    localparam int N = 4;

    logic         clock;
    logic         reset_n;
    logic         start;
    logic [N-1:0] A, B;
    logic         busy, done;
    logic [N-1:0] D;
    logic         Bout;

    int tests;
    int fails;
    logic [N-1:0] last_d;
    logic         last_b;

    serial_subtractor #(.N(N)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .done    (done),
        .D       (D),
        .Bout    (Bout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] d;
        logic         bout;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: plain modular arithmetic and unsigned compare.
    function automatic logic [N-1:0] ref_diff(input int a, input int b);
        return N'((a - b + (1 << N)) % (1 << N));
    endfunction

    function automatic logic ref_borrow(input int a, input int b);
        return (a < b);
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge after done.
    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input bit scramble);
        logic [N-1:0] ed;
        logic         eb;
        ed = ref_diff(int'(a), int'(b));
        eb = ref_borrow(int'(a), int'(b));
        A = a;
        B = b;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int w = 0; w <= N; w++) begin
            if (w > 0) @(negedge clock);
            if (scramble) begin
                A = N'($urandom);
                B = N'($urandom);
                start = 1'($urandom);
            end
            check("busy", 32'(busy), 32'(w < N));
            check("done", 32'(done), 32'(w == N));
            if (w < N) begin
                check("D_held_during_run", 32'(D), 32'(last_d));
                check("Bout_held_during_run", 32'(Bout), 32'(last_b));
            end
        end
        check("D", 32'(D), 32'(ed));
        check("Bout", 32'(Bout), 32'(eb));
        last_d = ed;
        last_b = eb;
        start = 1'b0;
        @(negedge clock);
        check("done_one_shot", 32'(done), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);
    endtask

    vec_t vecs[4];

    initial begin
        tests   = 0;
        fails   = 0;
        last_d  = '0;
        last_b  = 1'b0;
        reset_n = 1'b0;
        start   = 1'b0;
        A       = '0;
        B       = '0;

        vecs[0] = '{a: 4'b0101, b: 4'b0011, d: 4'b0010, bout: 1'b0};
        vecs[1] = '{a: 4'b0011, b: 4'b0101, d: 4'b1110, bout: 1'b1};
        vecs[2] = '{a: 4'b0000, b: 4'b0001, d: 4'b1111, bout: 1'b1};
        vecs[3] = '{a: 4'b1111, b: 4'b1111, d: 4'b0000, bout: 1'b0};

        // Reset state
        @(negedge clock);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_D", 32'(D), 32'd0);
        check("rst_Bout", 32'(Bout), 32'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_done", 32'(done), 32'd0);
            check("idle_D", 32'(D), 32'd0);
        end

        // Directed vectors with fixed expected results
        for (int i = 0; i < 4; i++) begin
            do_op(vecs[i].a, vecs[i].b, 1'b0);
            check("vec_D", 32'(last_d), 32'(vecs[i].d));
            check("vec_Bout", 32'(last_b), 32'(vecs[i].bout));
            if (i == 0) begin
                repeat (2) @(negedge clock);
                check("held3_D", 32'(D), 32'(vecs[0].d));
                check("held3_Bout", 32'(Bout), 32'(vecs[0].bout));
                check("held3_done", 32'(done), 32'd0);
            end
        end

        // Exhaustive back-to-back sweep; inputs and start randomised while busy
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                do_op(N'(a), N'(b), 1'b1);
            end
        end

        // start held high, operands changed right after capture
        A = 4'b1000;
        B = 4'b0001;
        start = 1'b1;
        @(negedge clock);
        A = 4'b0000;
        B = 4'b1111;
        for (int w = 0; w < 18; w++) begin
            if (w > 0) @(negedge clock);
            if (w == 17) start = 1'b0;
            check("held_busy", 32'(busy), 32'((w % 6) < 4));
            check("held_done", 32'(done), 32'((w % 6) == 4));
            if ((w % 6) == 4) begin
                if (w == 4) begin
                    check("held_D_first", 32'(D), 32'(ref_diff(8, 1)));
                    check("held_Bout_first", 32'(Bout), 32'(ref_borrow(8, 1)));
                end else begin
                    check("held_D_next", 32'(D), 32'(ref_diff(0, 15)));
                    check("held_Bout_next", 32'(Bout), 32'(ref_borrow(0, 15)));
                end
            end
        end
        last_d = ref_diff(0, 15);
        last_b = ref_borrow(0, 15);
        @(negedge clock);
        check("held_stop_busy", 32'(busy), 32'd0);

        // Reset during the 2nd RUN cycle aborts with no done pulse
        A = 4'b1001;
        B = 4'b0100;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("abort_busy_run1", 32'(busy), 32'd1);
        @(negedge clock);
        check("abort_busy_run2", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_D", 32'(D), 32'd0);
        check("abort_Bout", 32'(Bout), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        last_d = '0;
        last_b = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check("abort_no_done", 32'(done), 32'd0);
            check("abort_no_busy", 32'(busy), 32'd0);
        end
        do_op(4'b1001, 4'b0100, 1'b0);
        check("after_abort_D", 32'(D), 32'b0101);
        check("after_abort_Bout", 32'(Bout), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
